// File: rtl/acs_unit4.sv
// Add-compare-select stage for a K=3 rate-1/2 hard-decision Viterbi decoder.
// Holds normalized path metrics and emits survivor decisions plus best state.
module acs_unit4 #(
    parameter int PM_W    = 8,
    parameter int CNT_W   = 16,
    parameter int INIT_PM = 2**(PM_W-2)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic                sof,
    input  logic [15:0]         bm_in,
    output logic                out_valid,
    output logic [3:0]          dec_bits,
    output logic [4*PM_W-1:0]   pm_out,
    output logic [1:0]          best_state,
    output logic [CNT_W-1:0]    sym_cnt
);

    localparam logic [PM_W-1:0] INIT = PM_W'(INIT_PM);

    logic [PM_W-1:0]  r_pm     [4];
    logic [PM_W-1:0]  r_pm_out [4];
    logic             r_ov;
    logic [3:0]       r_dec;
    logic [1:0]       r_best;
    logic [CNT_W-1:0] r_cnt;

    logic [PM_W-1:0]  w_old  [4];
    logic [PM_W:0]    w_c0   [4];
    logic [PM_W:0]    w_c1   [4];
    logic [PM_W:0]    w_min  [4];
    logic [PM_W-1:0]  w_norm [4];
    logic [3:0]       w_dec;
    logic [3:0]       w_big;
    logic             w_sub;
    logic [1:0]       w_best;

    always_comb begin
        for (int s = 0; s < 4; s++) begin
            if (sof)
                w_old[s] = (s == 0) ? '0 : INIT;
            else
                w_old[s] = r_pm[s];
        end
    end

    // Next state n = {u, m} has predecessors 2m (decision 0) and 2m+1.
    for (genvar n = 0; n < 4; n++) begin : g_acs
        localparam int U  = n / 2;
        localparam int P0 = (n % 2) * 2;
        localparam int P1 = P0 + 1;

        assign w_c0[n] = {1'b0, w_old[P0]}
                       + (PM_W+1)'(bm_in[(P0*2+U)*2 +: 2]);
        assign w_c1[n] = {1'b0, w_old[P1]}
                       + (PM_W+1)'(bm_in[(P1*2+U)*2 +: 2]);
        assign w_dec[n] = (w_c1[n] < w_c0[n]);
        assign w_min[n] = w_dec[n] ? w_c1[n] : w_c0[n];
        assign w_big[n] = (w_min[n][PM_W:PM_W-1] != 2'b00);
        assign w_norm[n] = w_sub
            ? {1'b0, w_min[n][PM_W-2:0]}
            : w_min[n][PM_W-1:0];
        assign pm_out[n*PM_W +: PM_W] = r_pm_out[n];
    end

    assign w_sub = &w_big;

    always_comb begin
        w_best = 2'd0;
        for (int s = 1; s < 4; s++) begin
            if (w_norm[s] < w_norm[w_best])
                w_best = 2'(s);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 4; s++) begin
                r_pm[s]     <= (s == 0) ? '0 : INIT;
                r_pm_out[s] <= (s == 0) ? '0 : INIT;
            end
            r_ov   <= 1'b0;
            r_dec  <= '0;
            r_best <= '0;
            r_cnt  <= '0;
        end else if (in_valid) begin
            for (int s = 0; s < 4; s++) begin
                r_pm[s]     <= w_norm[s];
                r_pm_out[s] <= w_norm[s];
            end
            r_ov   <= 1'b1;
            r_dec  <= w_dec;
            r_best <= w_best;
            r_cnt  <= sof ? CNT_W'(1) : r_cnt + CNT_W'(1);
        end else begin
            r_ov <= 1'b0;
            if (sof) begin
                for (int s = 0; s < 4; s++)
                    r_pm[s] <= (s == 0) ? '0 : INIT;
                r_cnt <= '0;
            end
        end
    end

    assign out_valid  = r_ov;
    assign dec_bits   = r_dec;
    assign best_state = r_best;
    assign sym_cnt    = r_cnt;

endmodule

// File: tb/tb_acs_unit4.sv
// Randomized scoreboard bench for acs_unit4 against a trellis-level model.
// Expectations are queued after each edge and checked on the falling edge.
module tb_acs_unit4;

    localparam int PM_W  = 8;
    localparam int CNT_W = 16;
    localparam int INIT  = 64;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic                sof;
    logic [15:0]         bm_in;
    logic                out_valid;
    logic [3:0]          dec_bits;
    logic [4*PM_W-1:0]   pm_out;
    logic [1:0]          best_state;
    logic [CNT_W-1:0]    sym_cnt;

    always #5 clk = ~clk;

    acs_unit4 #(.PM_W(PM_W), .CNT_W(CNT_W), .INIT_PM(INIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .sof        (sof),
        .bm_in      (bm_in),
        .out_valid  (out_valid),
        .dec_bits   (dec_bits),
        .pm_out     (pm_out),
        .best_state (best_state),
        .sym_cnt    (sym_cnt)
    );

    typedef struct {
        logic              ov;
        logic [3:0]        dec;
        logic [4*PM_W-1:0] pm;
        logic [1:0]        best;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    int   mpm[4];
    exp_t mout;
    int   cur_bm[4][2];

    function automatic logic [4*PM_W-1:0] pack_pm(input int a0, a1, a2, a3);
        logic [4*PM_W-1:0] r;
        r = {PM_W'(a3), PM_W'(a2), PM_W'(a1), PM_W'(a0)};
        return r;
    endfunction

    function automatic void chk(input string nm, input longint act,
                                input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        mpm = '{0, INIT, INIT, INIT};
        mout.ov   = 1'b0;
        mout.dec  = '0;
        mout.best = '0;
        mout.cnt  = '0;
        mout.pm   = pack_pm(0, INIT, INIT, INIT);
    endtask

    // Every (state, input) pair is a branch into u*2 + msb(state).
    task automatic model_step(input bit sf, input bit v);
        int old[4];
        int npm[4];
        logic [3:0] d;
        int best;
        bit all_hi;
        if (sf) old = '{0, INIT, INIT, INIT};
        else    old = mpm;
        if (v) begin
            d = '0;
            for (int n = 0; n < 4; n++) npm[n] = 1 << 30;
            for (int s = 0; s < 4; s++) begin
                for (int u = 0; u < 2; u++) begin
                    int n;
                    int c;
                    n = u * 2 + s / 2;
                    c = old[s] + cur_bm[s][u];
                    if (c < npm[n]) begin
                        npm[n] = c;
                        d[n]   = (s % 2 == 1);
                    end
                end
            end
            all_hi = 1'b1;
            for (int n = 0; n < 4; n++)
                if (npm[n] < 128) all_hi = 1'b0;
            if (all_hi)
                for (int n = 0; n < 4; n++) npm[n] -= 128;
            best = 0;
            for (int n = 1; n < 4; n++)
                if (npm[n] < npm[best]) best = n;
            mpm       = npm;
            mout.ov   = 1'b1;
            mout.dec  = d;
            mout.best = 2'(best);
            mout.pm   = pack_pm(npm[0], npm[1], npm[2], npm[3]);
            mout.cnt  = sf ? CNT_W'(1) : mout.cnt + CNT_W'(1);
        end else begin
            mout.ov = 1'b0;
            if (sf) begin
                mpm      = '{0, INIT, INIT, INIT};
                mout.cnt = '0;
            end
        end
    endtask

    task automatic drive(input bit v, input bit sf);
        logic [15:0] b;
        for (int s = 0; s < 4; s++)
            for (int u = 0; u < 2; u++)
                b[(s*2+u)*2 +: 2] = 2'(cur_bm[s][u]);
        bm_in    = b;
        in_valid = v;
        sof      = sf;
        @(posedge clk);
        model_step(sf, v);
        q.push_back(mout);
        #1;
        in_valid = 1'b0;
        sof      = 1'b0;
    endtask

    task automatic set_bm_all(input int val);
        for (int s = 0; s < 4; s++)
            for (int u = 0; u < 2; u++)
                cur_bm[s][u] = val;
    endtask

    task automatic set_bm_rand();
        for (int s = 0; s < 4; s++)
            for (int u = 0; u < 2; u++)
                cur_bm[s][u] = int'($urandom_range(0, 3));
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("out_valid", out_valid, e.ov);
            chk("dec_bits", dec_bits, e.dec);
            chk("pm_out", pm_out, e.pm);
            chk("best_state", best_state, e.best);
            chk("sym_cnt", sym_cnt, e.cnt);
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_dec_bits"}, dec_bits, 0);
        chk({tag, "_pm_out"}, pm_out, pack_pm(0, INIT, INIT, INIT));
        chk({tag, "_best_state"}, best_state, 0);
        chk({tag, "_sym_cnt"}, sym_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sof      = 1'b0;
        bm_in    = '0;
        set_bm_all(0);
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        set_bm_all(0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);

        // Constant-3 metrics drive every path up until normalization.
        set_bm_all(3);
        drive(1'b1, 1'b1);
        for (int k = 2; k <= 45; k++)
            drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);

        drive(1'b0, 1'b1);
        set_bm_all(3);
        cur_bm[1][0] = 0;
        drive(1'b1, 1'b0);

        set_bm_all(3);
        cur_bm[2][0] = 3;
        cur_bm[3][0] = 0;
        cur_bm[2][1] = 0;
        cur_bm[3][1] = 0;
        drive(1'b1, 1'b1);

        drive(1'b0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            set_bm_rand();
            drive(1'b1, 1'b0);
        end
        set_bm_rand();
        drive(1'b1, 1'b1);

        for (int k = 0; k < 300; k++) begin
            set_bm_rand();
            drive(($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 99) < 3));
        end

        @(negedge clk);
        #1;
        chk("queue_drained_pre_reset", q.size(), 0);
        set_bm_rand();
        bm_in    = 16'($urandom);
        in_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk);
        #1;
        chk("async_rst_hold_valid", out_valid, 0);
        chk("async_rst_hold_cnt", sym_cnt, 0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        model_reset();

        for (int k = 0; k < 40; k++) begin
            set_bm_rand();
            drive(($urandom_range(0, 9) < 8),
                  ($urandom_range(0, 99) < 5));
        end

        repeat (3) @(negedge clk);
        #1;
        chk("queue_drained_end", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
